bypass_ctrl: RTL and testbench

//  Forwarding/hazard controller driving the Bypass_if control modport. Tracks register writes
//  of instructions in flight in the ALU and load/store (LS) pipelines and compares them with the

---
 rtl/bypass_ctrl_pkg.sv | 32 +++
 rtl/bypass_ctrl_if.sv | 11 +
 rtl/bypass_tracker.sv | 36 +++
 rtl/bypass_ctrl.sv | 116 +++++++++++
 tb/tb_bypass_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bypass_ctrl_pkg.sv
// Shared types for the operand bypass / load-use hazard controller.
// Tracker entries, forwarding line bundle and per-source select result.
package bypass_ctrl_pkg;

    localparam int unsigned REG_BITS = 5;

    typedef logic [REG_BITS-1:0] reg_idx_t;

    typedef enum logic {
        UNIT_ALU = 1'b0,
        UNIT_LS  = 1'b1
    } Issue_unit;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } Bypass_track_entry;

    typedef struct packed {
        logic alu_to_alu_a;
        logic alu_to_alu_b;
        logic ls_to_alu_a;
        logic ls_to_alu_b;
    } Bypass_line_ctrl;

    typedef struct packed {
        logic haz;
        logic alu;
        logic ls;
    } Bypass_src_sel;

endpackage

// File: rtl/bypass_ctrl_if.sv
// Forwarding line bundle from the bypass controller to the execute stage.
// The controller drives the lines; execute only reads them.
interface bypass_ctrl_if;
    import bypass_ctrl_pkg::*;

    Bypass_line_ctrl lines;

    modport control (output lines);
    modport execute (input lines);

endinterface

// File: rtl/bypass_tracker.sv
// Depth-N shift register of in-flight destination writes.
// Entry 0 is the youngest; every entry is exposed for comparison.
module bypass_tracker
    import bypass_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold_i,
    input  Bypass_track_entry             entry_i,
    output Bypass_track_entry [DEPTH-1:0] entries_o
);

    Bypass_track_entry [DEPTH-1:0] entries_q;
    Bypass_track_entry [DEPTH-1:0] entries_d;

    always_comb begin
        entries_d    = entries_q;
        entries_d[0] = entry_i;
        for (int i = 1; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
        end else if (!hold_i) begin
            entries_q <= entries_d;
        end
    end

    assign entries_o = entries_q;

endmodule

// File: rtl/bypass_ctrl.sv
// Forwarding and load-use hazard control for the issue slot.
// Matches issuing sources against ALU and LS trackers; youngest producer wins.
module bypass_ctrl
    import bypass_ctrl_pkg::*;
#(
    parameter int unsigned LS_LATENCY = 3
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     hold_i,
    input  logic     flush_i,
    input  logic     issue_valid_i,
    input  logic     issue_unit_i,
    input  reg_idx_t issue_ra_i,
    input  reg_idx_t issue_rb_i,
    input  logic     issue_use_a_i,
    input  logic     issue_use_b_i,
    input  reg_idx_t issue_rd_i,
    input  logic     issue_wr_i,
    output logic     issue_stall_o,
    output logic     issue_fire_o,
    bypass_ctrl_if.control ctrl
);

    Bypass_track_entry [0:0]            alu_e;
    Bypass_track_entry [LS_LATENCY-1:0] ls_e;
    Bypass_track_entry                  alu_in;
    Bypass_track_entry                  ls_in;

    Bypass_src_sel   sel_a;
    Bypass_src_sel   sel_b;
    logic            hazard;
    Bypass_line_ctrl lines_d;
    Bypass_line_ctrl lines_q;

    // Age order, youngest first: LS[0], ALU, LS[1] .. LS[LS_LATENCY-1].
    function automatic Bypass_src_sel pick(
        input logic                               use_s,
        input reg_idx_t                           s,
        input Bypass_track_entry [LS_LATENCY-1:0] ls,
        input Bypass_track_entry                  alu
    );
        Bypass_src_sel r;
        r = '0;
        for (int i = LS_LATENCY - 1; i >= 1; i--) begin
            if (ls[i].valid && ls[i].rd == s) begin
                r = '0;
                if (i == LS_LATENCY - 1) r.ls = 1'b1;
                else                     r.haz = 1'b1;
            end
        end
        if (alu.valid && alu.rd == s) begin
            r     = '0;
            r.alu = 1'b1;
        end
        if (ls[0].valid && ls[0].rd == s) begin
            r     = '0;
            r.haz = 1'b1;
        end
        if (!use_s) r = '0;
        return r;
    endfunction

    always_comb begin
        sel_a  = pick(issue_use_a_i, issue_ra_i, ls_e, alu_e[0]);
        sel_b  = pick(issue_use_b_i, issue_rb_i, ls_e, alu_e[0]);
        hazard = sel_a.haz | sel_b.haz;

        issue_stall_o = issue_valid_i & hazard
                      & ~flush_i & ~hold_i & ~reset;
        issue_fire_o  = issue_valid_i & ~hazard
                      & ~flush_i & ~hold_i & ~reset;

        lines_d = '0;
        if (issue_fire_o) begin
            lines_d.alu_to_alu_a = sel_a.alu;
            lines_d.alu_to_alu_b = sel_b.alu;
            lines_d.ls_to_alu_a  = sel_a.ls;
            lines_d.ls_to_alu_b  = sel_b.ls;
        end

        alu_in.valid = issue_fire_o & issue_wr_i
                     & (Issue_unit'(issue_unit_i) == UNIT_ALU);
        alu_in.rd    = issue_rd_i;
        ls_in.valid  = issue_fire_o & issue_wr_i
                     & (Issue_unit'(issue_unit_i) == UNIT_LS);
        ls_in.rd     = issue_rd_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_q <= '0;
        end else if (!hold_i) begin
            lines_q <= lines_d;
        end
    end

    assign ctrl.lines = lines_q;

    bypass_tracker #(.DEPTH(1)) u_alu_trk (
        .clk       (clk),
        .reset     (reset),
        .hold_i    (hold_i),
        .entry_i   (alu_in),
        .entries_o (alu_e)
    );

    bypass_tracker #(.DEPTH(LS_LATENCY)) u_ls_trk (
        .clk       (clk),
        .reset     (reset),
        .hold_i    (hold_i),
        .entry_i   (ls_in),
        .entries_o (ls_e)
    );

endmodule

// File: tb/tb_bypass_ctrl.sv
// Vector-table bench for bypass_ctrl with LS_LATENCY = 3.
// Registered lines are checked one cycle later through an expectation queue.
module tb_bypass_ctrl;

    localparam logic [3:0] N  = 4'h0;
    localparam logic [3:0] AA = 4'h8;
    localparam logic [3:0] AB = 4'h4;
    localparam logic [3:0] LA = 4'h2;
    localparam logic [3:0] LB = 4'h1;

    typedef struct {
        logic       valid;
        logic       unit;
        logic [4:0] ra;
        logic       ua;
        logic [4:0] rb;
        logic       ub;
        logic [4:0] rd;
        logic       wr;
        logic       hold;
        logic       flush;
        logic       stall;
        logic       fire;
        logic [3:0] lines;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold, flush, valid, unit, ua, ub, wr;
    logic [4:0] ra, rb, rd;
    logic       stall, fire;

    int passed = 0;
    int total  = 0;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    bypass_ctrl_if bif();

    bypass_ctrl #(.LS_LATENCY(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .hold_i        (hold),
        .flush_i       (flush),
        .issue_valid_i (valid),
        .issue_unit_i  (unit),
        .issue_ra_i    (ra),
        .issue_rb_i    (rb),
        .issue_use_a_i (ua),
        .issue_use_b_i (ub),
        .issue_rd_i    (rd),
        .issue_wr_i    (wr),
        .issue_stall_o (stall),
        .issue_fire_o  (fire),
        .ctrl          (bif)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        logic vl, logic un, logic [4:0] a, logic uaa, logic [4:0] b,
        logic ubb, logic [4:0] d, logic w, logic h, logic f,
        logic es, logic ef, logic [3:0] el
    );
        vec_t r;
        r.valid = vl; r.unit = un; r.ra = a; r.ua = uaa;
        r.rb = b; r.ub = ubb; r.rd = d; r.wr = w;
        r.hold = h; r.flush = f;
        r.stall = es; r.fire = ef; r.lines = el;
        return r;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(vec_t x);
        valid = x.valid; unit = x.unit; ra = x.ra; ua = x.ua;
        rb = x.rb; ub = x.ub; rd = x.rd; wr = x.wr;
        hold = x.hold; flush = x.flush;
    endtask

    // Called at posedge+1: drive, check comb outputs, check lines after edge.
    task automatic step(vec_t x, int idx);
        logic [3:0] e;
        drive(x);
        #3;
        chk($sformatf("stall[%0d]", idx), {3'b0, stall}, {3'b0, x.stall});
        chk($sformatf("fire[%0d]", idx), {3'b0, fire}, {3'b0, x.fire});
        exp_q.push_back(x.lines);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("lines[%0d]", idx), bif.lines, e);
    endtask

    initial begin
        vec_t idle;
        idle = v(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, N);
        drive(idle);

        // ALU to ALU, then register file
        vecs.push_back(v(1,0, 0,0, 0,0, 3,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 3,1, 0,0, 0,0, 0,0, 0,1, AA));
        vecs.push_back(v(1,0, 3,1, 0,0, 0,0, 0,0, 0,1, N));
        vecs.push_back(idle);
        // load-use on b
        vecs.push_back(v(1,1, 0,0, 0,0, 5,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 0,0, 5,1, 0,0, 0,0, 1,0, N));
        vecs.push_back(v(1,0, 0,0, 5,1, 0,0, 0,0, 1,0, N));
        vecs.push_back(v(1,0, 0,0, 5,1, 0,0, 0,0, 0,1, LB));
        vecs.push_back(idle);
        // youngest producer wins
        vecs.push_back(v(1,1, 0,0, 0,0, 7,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 0,0, 0,0, 7,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 7,1, 0,0, 0,0, 0,0, 0,1, AA));
        vecs.push_back(v(1,0, 7,1, 0,0, 0,0, 0,0, 0,1, LA));
        vecs.push_back(idle);
        // ra == rb, and unused b
        vecs.push_back(v(1,0, 0,0, 0,0, 4,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 4,1, 4,1, 0,0, 0,0, 0,1, AA|AB));
        vecs.push_back(v(1,0, 0,0, 0,0, 4,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 4,1, 4,0, 0,0, 0,0, 0,1, AA));
        vecs.push_back(idle);
        // flush drops stall and clears lines
        vecs.push_back(v(1,1, 0,0, 0,0, 9,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 9,1, 0,0, 0,0, 0,0, 1,0, N));
        vecs.push_back(v(1,0, 9,1, 0,0, 0,0, 0,1, 0,0, N));
        vecs.push_back(v(1,0, 9,1, 0,0, 0,0, 0,0, 0,1, LA));
        vecs.push_back(v(1,0, 0,0, 0,0, 6,1, 0,1, 0,0, N));
        vecs.push_back(v(1,0, 6,1, 0,0, 0,0, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 0,0, 0,0, 6,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 6,1, 0,0, 0,0, 0,1, 0,0, N));
        vecs.push_back(idle);
        // hold freezes tracker ages
        vecs.push_back(v(1,1, 0,0, 0,0, 10,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 0,0, 10,1, 0,0, 0,0, 1,0, N));
        vecs.push_back(v(1,0, 0,0, 10,1, 0,0, 1,0, 0,0, N));
        vecs.push_back(v(1,0, 0,0, 10,1, 0,0, 1,0, 0,0, N));
        vecs.push_back(v(1,0, 0,0, 10,1, 0,0, 0,0, 1,0, N));
        vecs.push_back(v(1,0, 0,0, 10,1, 0,0, 0,0, 0,1, LB));
        vecs.push_back(idle);
        // hold freezes ALU entry and lines
        vecs.push_back(v(1,0, 0,0, 0,0, 11,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 11,1, 0,0, 0,0, 1,0, 0,0, N));
        vecs.push_back(v(1,0, 11,1, 0,0, 0,0, 0,0, 0,1, AA));
        vecs.push_back(v(1,0, 11,1, 0,0, 0,0, 1,0, 0,0, AA));
        vecs.push_back(idle);
        // unused sources, invalid slot, load age boundaries
        vecs.push_back(v(1,1, 0,0, 0,0, 12,1, 0,0, 0,1, N));
        vecs.push_back(v(1,0, 12,0, 12,0, 0,0, 0,0, 0,1, N));
        vecs.push_back(v(0,0, 12,1, 0,0, 0,0, 0,0, 0,0, N));
        vecs.push_back(v(1,0, 0,0, 12,1, 0,0, 0,0, 0,1, LB));
        vecs.push_back(v(1,0, 12,1, 0,0, 0,0, 0,0, 0,1, N));
        vecs.push_back(idle);

        // reset state, fire gated while reset is high
        valid = 1'b1;
        #12;
        chk("rst_stall", {3'b0, stall}, 4'h0);
        chk("rst_fire", {3'b0, fire}, 4'h0);
        chk("rst_lines", bif.lines, N);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // reset during an in-flight load
        step(v(1,0, 0,0, 0,0, 14,1, 0,0, 0,1, N), 100);
        step(v(1,1, 14,1, 0,0, 13,1, 0,0, 0,1, AA), 101);
        drive(v(1,0, 13,1, 0,0, 0,0, 0,0, 0,0, N));
        #3;
        chk("pre_rst_stall", {3'b0, stall}, 4'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", {3'b0, stall}, 4'h0);
        chk("mid_rst_lines", bif.lines, N);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(v(1,0, 13,1, 0,0, 0,0, 0,0, 0,1, N), 102);

        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard: got %0d left expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
